// File: rtl/hs_ctrl_pkg.sv
// Shared definitions for the bundled-data receive handshake:
// FSM encoding, default synchroniser depth and a clog2 helper.
`timescale 1ns/1ps
package hs_ctrl_pkg;

    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_ACK  = 1'b1
    } hs_state_e;

    localparam int HS_SYNC_STAGES = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/hs_rx_fifo.sv
// First-word-fall-through receive FIFO with wrap-bit pointers;
// push into a full FIFO and pop from an empty one are ignored.
`timescale 1ns/1ps
module hs_rx_fifo
    import hs_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic [DATA_W-1:0]       wdata_i,
    input  logic                    pop_i,
    output logic [DATA_W-1:0]       rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [clog2(DEPTH):0]   count_o
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]       wr_q, wr_d;
    logic [AW:0]       rd_q, rd_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0])
                   && (wr_q[AW] != rd_q[AW]);
    assign empty_o = (wr_q == rd_q);
    assign count_o = wr_q - rd_q;
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + PTR_ONE;
        if (do_pop)  rd_d = rd_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: empty pointers hide stale words.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/hs_rack_responder.sv
// Receiver for a four-phase bundled-data channel: synchronises Rreq,
// stores Rdata in a FIFO and returns Rack, withholding it while full.
`timescale 1ns/1ps
module hs_rack_responder
    import hs_ctrl_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = HS_SYNC_STAGES,
    parameter int DEPTH       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    Rreq,
    input  logic [DATA_W-1:0]       Rdata,
    output logic                    Rack,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    out_ready,
    output logic [clog2(DEPTH):0]   count,
    output logic                    proto_err
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   req_prev_q;
    hs_state_e              state_q, state_d;
    logic                   err_q, err_d;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;

    assign req_s     = sync_q[SYNC_STAGES-1];
    assign Rack      = (state_q == HS_ACK);
    assign proto_err = err_q;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            req_prev_q <= 1'b0;
            state_q    <= HS_IDLE;
            err_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], Rreq};
            req_prev_q <= req_s;
            state_q    <= state_d;
            err_q      <= err_d;
        end
    end

    // A request seen falling while still unacknowledged was withdrawn.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        push    = 1'b0;
        unique case (state_q)
            HS_IDLE: begin
                if (req_s) begin
                    if (!full) begin
                        state_d = HS_ACK;
                        push    = 1'b1;
                    end
                end else if (req_prev_q) begin
                    err_d = 1'b1;
                end
            end
            HS_ACK: begin
                if (!req_s) state_d = HS_IDLE;
            end
            default: state_d = HS_IDLE;
        endcase
    end

    hs_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (Rdata),
        .pop_i   (pop),
        .rdata_o (out_data),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

endmodule

// File: tb/tb_hs_rack_responder.sv
// Scoreboard bench for hs_rack_responder: sender-side stimulus pushes
// expected words, a negedge monitor checks occupancy and drain order.
`timescale 1ns/1ps
module tb_hs_rack_responder;

    localparam int DW = 8;
    localparam int SS = 2;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          Rreq = 1'b0;
    logic [DW-1:0] Rdata = '0;
    logic          out_ready = 1'b0;
    logic          Rack;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [2:0]    count;
    logic          proto_err;

    hs_rack_responder #(
        .DATA_W      (DW),
        .SYNC_STAGES (SS),
        .DEPTH       (DP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Rreq      (Rreq),
        .Rdata     (Rdata),
        .Rack      (Rack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q [$];
    int            occ = 0;
    bit            pop_pend = 0;
    logic          rack_prev = 1'b0;
    bit            stop = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: occupancy rises with each acknowledge, falls one edge after
    // a consumer handshake; words leave in the order they were sent.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            occ = 0;
            pop_pend = 0;
            rack_prev = 1'b0;
        end else begin
            if (pop_pend) occ--;
            if (Rack && !rack_prev) occ++;
            rack_prev = Rack;
            chk("count", count, occ);
            chk("out_valid", out_valid, occ != 0);
            pop_pend = (occ != 0) && out_ready;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL pop_underflow: got %0h expected none", out_data);
                end else begin
                    chk("data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rack(input logic v, input string nm);
        int k;
        k = 0;
        while (Rack !== v && k < 100) begin
            tick();
            k++;
        end
        chk(nm, Rack, v);
    endtask

    task automatic send(input logic [DW-1:0] d);
        Rdata = d;
        exp_q.push_back(d);
        Rreq = 1'b1;
        wait_rack(1'b1, "ack_rise");
        Rreq = 1'b0;
        wait_rack(1'b0, "ack_fall");
        Rdata = DW'($urandom);
    endtask

    task automatic drain();
        int k;
        k = 0;
        out_ready = 1'b1;
        while (out_valid && k < 50) begin
            tick();
            k++;
        end
        out_ready = 1'b0;
        tick();
        chk("drained", out_valid, 1'b0);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_rack", Rack, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_err", proto_err, 1'b0);
        rst = 1'b1;
        repeat (2) tick();
        chk("post_rst_rack", Rack, 1'b0);
        chk("post_rst_err", proto_err, 1'b0);

        // Single word with edge-exact latency.
        Rdata = 8'hA5;
        exp_q.push_back(8'hA5);
        Rreq = 1'b1;
        tick();
        tick();
        chk("lat_rise_early", Rack, 1'b0);
        tick();
        chk("lat_rise", Rack, 1'b1);
        chk("single_valid", out_valid, 1'b1);
        chk("single_data", out_data, 8'hA5);
        Rreq = 1'b0;
        tick();
        tick();
        chk("lat_fall_early", Rack, 1'b1);
        tick();
        chk("lat_fall", Rack, 1'b0);
        drain();

        // Fill and back-pressure.
        for (int i = 1; i <= 4; i++) send(DW'(i));
        chk("fill_count", count, 4);
        Rdata = 8'h05;
        exp_q.push_back(8'h05);
        Rreq = 1'b1;
        repeat (8) tick();
        chk("bp_rack", Rack, 1'b0);
        chk("bp_count", count, 4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_hold", Rack, 1'b0);
        tick();
        chk("bp_release", Rack, 1'b1);
        chk("bp_count_after", count, 4);
        Rreq = 1'b0;
        wait_rack(1'b0, "bp_fall");
        drain();

        // Push and pop on the same edge at count 2.
        send(8'h11);
        send(8'h22);
        chk("sim_pre", count, 2);
        Rdata = 8'h33;
        exp_q.push_back(8'h33);
        Rreq = 1'b1;
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("sim_rack", Rack, 1'b1);
        chk("sim_count", count, 2);
        Rreq = 1'b0;
        wait_rack(1'b0, "sim_fall");
        drain();

        // Streaming across pointer wrap, then random consumer stalls.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) send(DW'($urandom));
        drain();
        chk("wrap_err", proto_err, 1'b0);
        stop = 0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    send(DW'($urandom));
                end
                stop = 1;
            end
            begin
                while (!stop) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        drain();
        chk("rand_err", proto_err, 1'b0);

        // Request withdrawn while back-pressured.
        for (int i = 0; i < 4; i++) send(DW'(8'h40 + i));
        Rdata = 8'hEE;
        Rreq = 1'b1;
        repeat (6) tick();
        Rreq = 1'b0;
        repeat (6) tick();
        chk("viol_err", proto_err, 1'b1);
        chk("viol_count", count, 4);
        chk("viol_rack", Rack, 1'b0);
        drain();
        chk("viol_sticky", proto_err, 1'b1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("viol_cleared", proto_err, 1'b0);

        // Asynchronous reset while acknowledging with 3 words stored.
        send(8'h71);
        send(8'h72);
        Rdata = 8'h73;
        exp_q.push_back(8'h73);
        Rreq = 1'b1;
        wait_rack(1'b1, "ar_ack");
        chk("ar_count_pre", count, 3);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_rack", Rack, 1'b0);
        chk("ar_count", count, 0);
        chk("ar_valid", out_valid, 1'b0);
        Rreq = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("ar_after_count", count, 0);
        chk("ar_after_rack", Rack, 1'b0);

        chk("leftover", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
